// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, default frame format and clogb2.
// Used by both the transmitter and the receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SYNC   = 3'd1,
    ST_START  = 3'd2,
    ST_DATA   = 3'd3,
    ST_PARITY = 3'd4,
    ST_STOP   = 3'd5
  } uart_state_e;

  localparam int UART_DATA_BITS_DEF = 8;
  localparam int UART_STOP_BITS_DEF = 1;

  // Ceiling log2 of value (0 for value <= 1).
  function automatic int clogb2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/uart_tx.sv
// UART transmitter: byte in over valid/ready, frame out on txd paced by bps_clk.
// Define UART_TX_PARITY_EN to insert an even parity bit after the data bits.
module uart_tx
  import uart_pkg::*;
#(
  parameter int DATA_BITS = UART_DATA_BITS_DEF,
  parameter int STOP_BITS = UART_STOP_BITS_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tx_valid,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx_ready,
  input  logic                 bps_clk,
  output logic                 uart_en,
  output logic                 txd,
  output logic                 tx_busy
);

  localparam int CNT_W = clogb2(DATA_BITS) + 1;

  if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_bad_data_bits
    $error("uart_tx: DATA_BITS must be in 5..8");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
    $error("uart_tx: STOP_BITS must be 1 or 2");
  end

  uart_state_e          state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic                 txd_q, txd_d;
  logic                 uart_en_q, uart_en_d;
  logic                 tx_ready_q, tx_ready_d;
  logic                 tx_busy_q, tx_busy_d;
`ifdef UART_TX_PARITY_EN
  logic                 parity_q, parity_d;
`endif

  // Handshake: a byte transfers on a rising clk edge where tx_valid && tx_ready;
  // tx_ready is high only in IDLE, so tx_valid at any other time is ignored.
  logic hs;
  logic last_data;
  logic last_stop;

  assign hs        = tx_valid && tx_ready_q;
  assign last_data = (bit_cnt_q >= CNT_W'(DATA_BITS));
  assign last_stop = (bit_cnt_q == CNT_W'(STOP_BITS - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (hs) state_d = ST_SYNC;
      ST_SYNC:  if (bps_clk) state_d = ST_START;
      ST_START: if (bps_clk) state_d = ST_DATA;
      ST_DATA: begin
        if (bps_clk && last_data) begin
`ifdef UART_TX_PARITY_EN
          state_d = ST_PARITY;
`else
          state_d = ST_STOP;
`endif
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: if (bps_clk) state_d = ST_STOP;
`endif
      ST_STOP:  if (bps_clk && last_stop) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Line level changes only on bps_clk pulses, so every bit lasts one full period.
  always_comb begin
    txd_d = txd_q;
    case (state_q)
      ST_IDLE:  txd_d = 1'b1;
      ST_SYNC:  if (bps_clk) txd_d = 1'b0;
      ST_START: if (bps_clk) txd_d = shift_q[0];
      ST_DATA: begin
        if (bps_clk) begin
          if (!last_data) txd_d = shift_q[0];
`ifdef UART_TX_PARITY_EN
          else            txd_d = parity_q;
`else
          else            txd_d = 1'b1;
`endif
        end
      end
      ST_PARITY: if (bps_clk) txd_d = 1'b1;
      ST_STOP:  txd_d = 1'b1;
      default:  txd_d = 1'b1;
    endcase
    uart_en_d  = (state_d != ST_IDLE);
    tx_ready_d = (state_d == ST_IDLE);
    tx_busy_d  = (state_d != ST_IDLE);
  end

  // bit_cnt counts data bits, then is reused to count stop-bit pulses.
  always_comb begin
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
`ifdef UART_TX_PARITY_EN
    parity_d  = parity_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (hs) begin
          shift_d   = tx_data;
          bit_cnt_d = '0;
`ifdef UART_TX_PARITY_EN
          parity_d  = ^tx_data;
`endif
        end
      end
      ST_START: begin
        if (bps_clk) begin
          shift_d   = shift_q >> 1;
          bit_cnt_d = CNT_W'(1);
        end
      end
      ST_DATA: begin
        if (bps_clk) begin
          if (!last_data) begin
            shift_d   = shift_q >> 1;
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
          end else begin
            bit_cnt_d = '0;
          end
        end
      end
      ST_STOP: begin
        if (bps_clk) bit_cnt_d = last_stop ? '0 : bit_cnt_q + CNT_W'(1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      txd_q      <= 1'b1;
      uart_en_q  <= 1'b0;
      tx_ready_q <= 1'b1;
      tx_busy_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q   <= 1'b0;
`endif
    end else begin
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      txd_q      <= txd_d;
      uart_en_q  <= uart_en_d;
      tx_ready_q <= tx_ready_d;
      tx_busy_q  <= tx_busy_d;
`ifdef UART_TX_PARITY_EN
      parity_q   <= parity_d;
`endif
    end
  end

  assign txd      = txd_q;
  assign uart_en  = uart_en_q;
  assign tx_ready = tx_ready_q;
  assign tx_busy  = tx_busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: table of bytes through a frame-decoding scoreboard plus
// directed sequences for timing corners; 8N1 and 8N2 instances share bps_clk.
module tb_uart_tx;

`ifdef UART_TX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int BIT_CLKS = 16;

  typedef struct {
    logic [7:0] data;
    logic       par;
  } vec_t;

  logic       clk, rst, bps_clk;
  logic       tx_valid, tx_ready, uart_en, txd, tx_busy;
  logic [7:0] tx_data;
  logic       tx_valid2, tx_ready2, uart_en2, txd2, tx_busy2;
  logic [7:0] tx_data2;

  int         checks, errors;
  int         frames_sent, frames_seen;
  int         bps_cnt;
  logic       bps_at_edge;
  logic       mon_en;
  logic [8:0] exp_q[$];
  vec_t       vecs[8];

  uart_tx #(.DATA_BITS(8), .STOP_BITS(1)) dut (
    .clk(clk), .rst(rst), .tx_valid(tx_valid), .tx_data(tx_data),
    .tx_ready(tx_ready), .bps_clk(bps_clk), .uart_en(uart_en),
    .txd(txd), .tx_busy(tx_busy)
  );

  uart_tx #(.DATA_BITS(8), .STOP_BITS(2)) dut2 (
    .clk(clk), .rst(rst), .tx_valid(tx_valid2), .tx_data(tx_data2),
    .tx_ready(tx_ready2), .bps_clk(bps_clk), .uart_en(uart_en2),
    .txd(txd2), .tx_busy(tx_busy2)
  );

  // clock / baud pulse
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    bps_cnt = 0;
    bps_clk = 1'b0;
    forever begin
      @(negedge clk);
      bps_cnt = (bps_cnt + 1) % BIT_CLKS;
      bps_clk = (bps_cnt == 0);
    end
  end

  always @(posedge clk) bps_at_edge <= bps_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: wait expired at %0t", name, $time);
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    @(negedge clk);
    while (!(tx_ready && !tx_busy) && t < 1000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 1000) timeout("wait_idle");
  endtask

  task automatic send(input logic [7:0] d, input logic p);
    int t;
    @(negedge clk);
    tx_valid = 1'b1;
    tx_data  = d;
    t = 0;
    while (!tx_ready && t < 1000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 1000) begin
      timeout("send_ready");
      tx_valid = 1'b0;
      return;
    end
    exp_q.push_back({p, d});
    frames_sent++;
    @(negedge clk);
    tx_valid = 1'b0;
    check("hs_uart_en", uart_en, 1);
    check("hs_tx_ready", tx_ready, 0);
  endtask

  // txd may only move on an edge where bps_clk was high (reset excepted)
  initial begin
    logic prev_txd, prev_rst;
    prev_txd = 1'b1;
    prev_rst = 1'b1;
    forever begin
      @(negedge clk);
      if (!rst && !prev_rst && txd !== prev_txd) check("txd_edge_on_bps", bps_at_edge, 1);
      prev_txd = txd;
      prev_rst = rst;
    end
  end

  // scoreboard monitor: decode each frame at mid-bit and compare to exp_q
  initial begin
    logic       prev;
    logic [7:0] d;
    logic [8:0] e;
    logic       p, s;
    prev = 1'b1;
    forever begin
      @(negedge clk);
      if (mon_en && !rst && prev && !txd) begin
        repeat (BIT_CLKS / 2) @(negedge clk);
        check("frame_start_bit", txd, 0);
        for (int i = 0; i < 8; i++) begin
          repeat (BIT_CLKS) @(negedge clk);
          d[i] = txd;
        end
        p = 1'b0;
`ifdef UART_TX_PARITY_EN
        repeat (BIT_CLKS) @(negedge clk);
        p = txd;
`endif
        repeat (BIT_CLKS) @(negedge clk);
        s = txd;
        check("frame_stop_bit", s, 1);
        frames_seen++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL frame_unexpected: got %0h expected none", d);
        end else begin
          e = exp_q.pop_front();
          check("frame_data", d, e[7:0]);
`ifdef UART_TX_PARITY_EN
          check("frame_parity", p, e[8]);
`endif
        end
      end
      prev = txd;
    end
  end

  initial begin
    int n, lo, hi, en_low, ones;
    checks = 0; errors = 0; frames_sent = 0; frames_seen = 0;
    rst = 1'b1; mon_en = 1'b1;
    tx_valid = 1'b0; tx_data = '0; tx_valid2 = 1'b0; tx_data2 = '0;
    vecs[0] = '{8'hA5, 1'b0};
    vecs[1] = '{8'h07, 1'b1};
    vecs[2] = '{8'h00, 1'b0};
    vecs[3] = '{8'hFF, 1'b0};
    vecs[4] = '{8'h3C, 1'b0};
    vecs[5] = '{8'h80, 1'b1};
    vecs[6] = '{8'h5B, 1'b1};
    vecs[7] = '{8'hE1, 1'b0};

    repeat (3) @(negedge clk);
    check("rst_txd", txd, 1);
    check("rst_uart_en", uart_en, 0);
    check("rst_tx_ready", tx_ready, 1);
    check("rst_tx_busy", tx_busy, 0);
    check("rst_txd2", txd2, 1);
    check("rst_tx_ready2", tx_ready2, 1);
    rst = 1'b0;

    // 0xA5: start bit exactly one period, uart_en high for the whole frame
    wait_idle();
    send(8'hA5, 1'b0);
    n = 0;
    while (txd && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) timeout("a5_start_wait");
    lo = 0;
    while (!txd && lo < 100) begin @(negedge clk); lo++; end
    check("a5_start_len", lo, BIT_CLKS);
    hi = 0; en_low = 0;
    while (!tx_ready && hi < 400) begin
      if (!uart_en) en_low++;
      @(negedge clk);
      hi++;
    end
    check("a5_rest_len", hi, BIT_CLKS * (9 + PAR));
    check("a5_uart_en_gaps", en_low, 0);
    check("a5_uart_en_after", uart_en, 0);

    // handshake on the same edge as a bps pulse: that pulse must not start the frame
    wait_idle();
    n = 0;
    do begin @(negedge clk); #1; n++; end while (!bps_clk && n < 40);
    tx_valid = 1'b1; tx_data = 8'h5A;
    exp_q.push_back({1'b0, 8'h5A});
    frames_sent++;
    @(negedge clk);
    tx_valid = 1'b0;
    n = 0;
    while (txd && n < 100) begin n++; @(negedge clk); end
    check("coincident_sync_len", n, BIT_CLKS);

    // table of bytes, sent back to back
    wait_idle();
    for (int i = 0; i < 8; i++) send(vecs[i].data, vecs[i].par);

    // tx_valid held high across two frames
    wait_idle();
    @(negedge clk);
    tx_valid = 1'b1; tx_data = 8'h11;
    exp_q.push_back({1'b0, 8'h11});
    frames_sent++;
    @(negedge clk);
    tx_data = 8'h22;
    exp_q.push_back({1'b0, 8'h22});
    frames_sent++;
    n = 0;
    while (uart_en && n < 400) begin @(negedge clk); n++; end
    if (n >= 400) timeout("b2b_first_end");
    lo = 0;
    while (!uart_en && lo < 20) begin @(negedge clk); lo++; end
    check("b2b_uart_en_gap", lo, 1);
    check("b2b_busy", tx_busy, 1);
    tx_valid = 1'b0;
    tx_data  = 8'hC3;

    // tx_valid pulsed with new data mid-frame
    wait_idle();
    send(8'h66, 1'b0);
    repeat (40) @(negedge clk);
    tx_data = 8'h99; tx_valid = 1'b1;
    @(negedge clk);
    check("midframe_ready", tx_ready, 0);
    check("midframe_busy", tx_busy, 1);
    tx_valid = 1'b0;
    wait_idle();
    repeat (40) @(negedge clk);
    check("midframe_no_extra", tx_busy, 0);

    // two stop bits, 0xFF
    @(negedge clk);
    tx_valid2 = 1'b1; tx_data2 = 8'hFF;
    @(negedge clk);
    tx_valid2 = 1'b0;
    check("s2_uart_en", uart_en2, 1);
    n = 0;
    while (txd2 && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) timeout("s2_start_wait");
    lo = 0;
    while (!txd2 && lo < 100) begin @(negedge clk); lo++; end
    check("s2_start_len", lo, BIT_CLKS);
    hi = 0; ones = 0;
    while (!tx_ready2 && hi < 400) begin
      if (txd2) ones++;
      @(negedge clk);
      hi++;
    end
    check("s2_rest_len", hi, BIT_CLKS * (10 + PAR));
    check("s2_high_len", ones, BIT_CLKS * 10);
    check("s2_uart_en_after", uart_en2, 0);

    // reset during data bit 3 of 0xF0 (bit 3 is 0)
    wait_idle();
    mon_en = 1'b0;
    @(negedge clk);
    tx_valid = 1'b1; tx_data = 8'hF0;
    @(negedge clk);
    tx_valid = 1'b0;
    n = 0;
    while (txd && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) timeout("rst_frame_start");
    repeat (BIT_CLKS + 3 * BIT_CLKS + BIT_CLKS / 2) @(negedge clk);
    check("pre_reset_txd", txd, 0);
    check("pre_reset_busy", tx_busy, 1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_txd", txd, 1);
    check("async_rst_uart_en", uart_en, 0);
    check("async_rst_tx_ready", tx_ready, 1);
    check("async_rst_tx_busy", tx_busy, 0);
    @(negedge clk);
    #2 rst = 1'b0;
    mon_en = 1'b1;
    send(8'h3C, 1'b0);

    wait_idle();
    repeat (20) @(negedge clk);
    check("scoreboard_empty", exp_q.size(), 0);
    check("frame_count", frames_seen, frames_sent);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
UART serial transmitter and the consumer side of the baud clock generator interface. It accepts a parallel byte through a valid/ready handshake and raises uart_en to start the baud generator. It then drives txd one bit per bps_clk pulse: start, data LSB-first, optional parity, stop. It sits inside the UART top level, beside the receiver, and shares one baud generator instance.

Parameters:
DATA_BITS, 8, data bits per frame; legal range 5..8.
STOP_BITS, 1, stop bits per frame; legal values 1 or 2.

Ports:
clk  input  1  system clock.
rst  input  1  asynchronous reset, active-high.
tx_valid  input  1  tx_data is valid this cycle.
tx_data  input  DATA_BITS  byte to send; sampled on handshake.
tx_ready  output  1  block can accept a byte (high only in IDLE).
bps_clk  input  1  one-clk-wide pulse per bit period, from the baud generator.
uart_en  output  1  enable request to the baud generator.
txd  output  1  serial line; idles high.
tx_busy  output  1  a frame is in progress (state != IDLE).

Behaviour:
- Interface: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: txd=1, uart_en=0, tx_ready=1, tx_busy=0, state=IDLE, shift register=0, bit counter=0.
- Handshake: a transfer occurs when tx_valid && tx_ready on a rising clk edge.
  - tx_data is latched into the shift register at that edge.
  - tx_data is ignored at all other times.
- FSM states: IDLE, SYNC, START, DATA, PARITY, STOP. All outputs are registered.
- IDLE: txd=1, uart_en=0. On a transfer, go to SYNC and set uart_en=1 on the next cycle.
- SYNC: txd=1. Wait for the first bps_clk pulse. On that pulse, txd<=0 and go to START.
  - Purpose: the start bit lasts exactly one full bit period regardless of baud generator startup latency.
- START: on bps_clk, txd<=shift[0], shift right, bit_cnt<=1, go to DATA.
- DATA: on bps_clk:
  - If bit_cnt<DATA_BITS: txd<=shift[0], shift right, bit_cnt+1.
  - Otherwise: go to PARITY (if enabled) or STOP, with txd<=parity or 1 respectively.
- PARITY: on bps_clk, txd<=1, go to STOP.
- STOP: txd=1.
  - Counts STOP_BITS bps_clk pulses.
  - On the final pulse, go to IDLE and deassert uart_en in the same edge.
- bps_clk pulses in IDLE are ignored. Between pulses, txd holds its value.
- bit_cnt width: clog2(DATA_BITS)+1. It never wraps within a frame.
- Back-to-back frames: tx_ready rises one cycle after STOP completes. uart_en is low for at least one clk between frames.
- tx_valid while busy: no effect. Data is not latched and tx_ready stays low.
- bps_clk coincident with a handshake in IDLE: the handshake wins and the pulse is ignored.
- Reset mid-frame: all state returns immediately to reset values.
  - txd goes high asynchronously. This may truncate the frame on the line.
  - uart_en drops, which stops the baud generator.
- Illegal parameter values are a compile-time error.

Optional Feature:
Macro UART_TX_PARITY_EN.
- Defined: the PARITY state exists, and an even parity bit (XOR of the latched data bits) is sent after the last data bit. Frame = 1 + DATA_BITS + 1 + STOP_BITS bit periods.
- Undefined: the PARITY state and parity logic are removed, and DATA goes directly to STOP. Frame = 1 + DATA_BITS + STOP_BITS bit periods.

Decomposition:
- Shared package uart_pkg holds:
  - the FSM state encoding constants (IDLE, SYNC, START, DATA, PARITY, STOP; 3-bit);
  - the clogb2 function;
  - default DATA_BITS/STOP_BITS constants, reused by the receiver.
- No sub-module. The shift register and counter stay inline.
- The baud generator is instantiated at the UART top level, not inside this block.

Test Plan:
1. Send 0xA5 with a bench pulse every 16 clk, 8N1 -> after SYNC, txd = 0,1,0,1,0,0,1,0,1,1, each held exactly 16 clk. uart_en=1 from the cycle after the handshake until the final stop pulse.
2. UART_TX_PARITY_EN defined, data 0x07 -> parity bit is 1. Data 0x00 -> parity bit is 0. Frame is 11 bit periods.
3. STOP_BITS=2, data 0xFF -> txd low for one period, then high for 10 periods. tx_ready rises one clk after the 10th stop-period pulse.
4. Hold tx_valid high with data 0x11, then 0x22 -> two frames back-to-back. uart_en is low for exactly 1 clk between them. The second frame carries 0x22, not a value changed mid-frame.
5. Change tx_data and pulse tx_valid mid-frame -> no effect on txd; tx_ready stays 0.
6. Assert rst during DATA bit 3 -> txd=1, uart_en=0, tx_ready=1 in the same cycle. A subsequent 0x3C frame is correct.
